// File: rtl/mem_pkg.sv
// Shared constants, state encoding and load/store lane helpers for the MEM stage.
package mem_pkg;

  localparam int unsigned XLEN_W  = 64;
  localparam int unsigned BYTES_W = XLEN_W / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    OUT       = 2'd2
  } state_t;

  // Byte enables for a store of the given size at byte offset off.
  function automatic logic [BYTES_W-1:0] store_be(input logic [2:0] funct3,
                                                  input logic [2:0] off);
    logic [BYTES_W-1:0] be;
    case (funct3[1:0])
      2'b00:   be = 8'h01 << off;
      2'b01:   be = 8'h03 << off;
      2'b10:   be = 8'h0F << off;
      default: be = 8'hFF;
    endcase
    return be;
  endfunction

  // True when the access size does not divide the byte offset.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [2:0] off);
    logic mis;
    case (funct3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = off[0];
      2'b10:   mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

  // Extract the addressed lane and sign/zero extend; 3'b111 behaves as LD.
  function automatic logic [XLEN_W-1:0] load_format(input logic [2:0]        funct3,
                                                    input logic [2:0]        off,
                                                    input logic [XLEN_W-1:0] word);
    logic [XLEN_W-1:0] sh;
    logic [XLEN_W-1:0] res;
    sh = word >> {off, 3'b000};
    case (funct3)
      F3_B:    res = {{56{sh[7]}},  sh[7:0]};
      F3_H:    res = {{48{sh[15]}}, sh[15:0]};
      F3_W:    res = {{32{sh[31]}}, sh[31:0]};
      F3_BU:   res = {56'd0, sh[7:0]};
      F3_HU:   res = {48'd0, sh[15:0]};
      F3_WU:   res = {32'd0, sh[31:0]};
      F3_D:    res = sh;
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_stage_ram.sv
// Single-port data RAM, byte write enables, read data delayed by RD_LATENCY registers.
module mem_stage_ram #(
  parameter  int unsigned XLEN        = 64,
  parameter  int unsigned DEPTH_WORDS = 1024,
  parameter  int unsigned RD_LATENCY  = 1,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS),
  localparam int unsigned NBYTES      = XLEN / 8
) (
  input  logic              clk_i,
  input  logic              re_i,
  input  logic [NBYTES-1:0] be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   rdata_o
);

  logic [XLEN-1:0] mem_q     [DEPTH_WORDS];
  logic [XLEN-1:0] rd_pipe_q [RD_LATENCY];

  // Byte-masked write, read capture into the first pipe stage, then shift the pipe.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < int'(NBYTES); b++) begin
      if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (re_i) rd_pipe_q[0] <= mem_q[addr_i];
    for (int s = 1; s < int'(RD_LATENCY); s++) begin
      rd_pipe_q[s] <= rd_pipe_q[s-1];
    end
  end

  assign rdata_o = rd_pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/mem_stage.sv
// RV64 MEM stage: RAM loads/stores with valid/ready on both sides and write-back select.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic            mem_to_reg_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic [XLEN-1:0] wr_data_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            reg_write_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_write_o,
  output logic            misaligned_o
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned CNT_W  = 3;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic              reg_write_q, reg_write_d;
  logic              mis_q, mis_d;
  logic              m2r_q, m2r_d;
  logic [2:0]        f3_q, f3_d;
  logic [2:0]        off_q, off_d;
  logic [XLEN-1:0]   alu_q, alu_d;

  logic              accept_c;
  logic              is_store_c;
  logic              is_load_c;
  logic              mis_c;
  logic              ram_re_c;
  logic [NBYTES-1:0] ram_be_c;
  logic [XLEN-1:0]   ram_wdata_c;
  logic [XLEN-1:0]   ram_rdata_c;
  logic [AW-1:0]     word_idx_c;
  logic              unused_addr_c;

  // Upstream handshake: only an idle stage or a draining output stage can take an op.
  assign ready_o  = (state_q == IDLE) || ((state_q == OUT) && ready_i);
  assign accept_c = valid_i && ready_o;

  // Op decode; read+write together is a store. Address bits above the RAM wrap.
  assign is_store_c    = mem_write_i;
  assign is_load_c     = mem_read_i && !mem_write_i;
  assign mis_c         = (is_store_c || is_load_c) && is_misaligned(funct3_i, mem_addr_i[2:0]);
  assign ram_re_c      = accept_c && is_load_c && !mis_c;
  assign ram_be_c      = (accept_c && is_store_c && !mis_c && !rst_i)
                         ? NBYTES'(store_be(funct3_i, mem_addr_i[2:0])) : '0;
  assign ram_wdata_c   = wr_data_i << {mem_addr_i[2:0], 3'b000};
  assign word_idx_c    = mem_addr_i[AW+2:3];
  assign unused_addr_c = ^mem_addr_i[XLEN-1:AW+3];

  mem_stage_ram #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS),
    .RD_LATENCY  (RD_LATENCY)
  ) u_ram (
    .clk_i   (clk_i),
    .re_i    (ram_re_c),
    .be_i    (ram_be_c),
    .addr_i  (word_idx_c),
    .wdata_i (ram_wdata_c),
    .rdata_o (ram_rdata_c)
  );

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    rd_data_d   = rd_data_q;
    rd_addr_d   = rd_addr_q;
    reg_write_d = reg_write_q;
    mis_d       = mis_q;
    m2r_d       = m2r_q;
    f3_d        = f3_q;
    off_d       = off_q;
    alu_d       = alu_q;
    case (state_q)
      IDLE, OUT: begin
        if ((state_q == OUT) && ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
        if (accept_c) begin
          rd_addr_d = rd_addr_i;
          m2r_d     = mem_to_reg_i;
          f3_d      = funct3_i;
          off_d     = mem_addr_i[2:0];
          alu_d     = alu_result_i;
          mis_d     = mis_c;
          if (ram_re_c) begin
            state_d     = LOAD_WAIT;
            cnt_d       = CNT_W'(RD_LATENCY - 1);
            valid_d     = 1'b0;
            reg_write_d = reg_write_i;
          end else begin
            state_d     = OUT;
            valid_d     = 1'b1;
            reg_write_d = reg_write_i && !is_store_c && !mis_c;
            rd_data_d   = mis_c ? '0 : (mem_to_reg_i ? alu_result_i : '0);
          end
        end
      end
      LOAD_WAIT: begin
        if (cnt_q == '0) begin
          state_d   = OUT;
          valid_d   = 1'b1;
          rd_data_d = m2r_q ? alu_q : XLEN'(load_format(f3_q, off_q, ram_rdata_c));
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and stage registers with synchronous reset; a pending read is dropped on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      rd_data_q   <= '0;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
      mis_q       <= 1'b0;
      m2r_q       <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      alu_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      rd_data_q   <= rd_data_d;
      rd_addr_q   <= rd_addr_d;
      reg_write_q <= reg_write_d;
      mis_q       <= mis_d;
      m2r_q       <= m2r_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      alu_q       <= alu_d;
    end
  end

  assign valid_o      = valid_q;
  assign rd_data_o    = rd_data_q;
  assign rd_addr_o    = rd_addr_q;
  assign reg_write_o  = reg_write_q;
  assign misaligned_o = mis_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Parametrised pipeline MEM stage for the RISC-V core. Sits between the EX/MEM pipeline register and write-back.
- Owns a byte-addressable data RAM and performs RV64 loads (sign/zero-extended) and stores (byte-enabled).
- Selects the write-back value between load data and ALU result.
- Uses valid/ready handshakes on both sides, so multi-cycle RAM latency stalls the pipeline cleanly.

Parameters:
- XLEN, 64, data/address width; fixed at 64 for RV64, 8-byte words.
- DEPTH_WORDS, 1024, RAM depth in XLEN-bit words; power of two.
- RD_LATENCY, 1, RAM read latency in cycles; range 1..4.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  upstream op valid
- ready_o  out  1  stage can accept an op this cycle
- mem_read_i  in  1  op is a load
- mem_write_i  in  1  op is a store
- mem_to_reg_i  in  1  0 = write back load data, 1 = write back alu_result_i
- funct3_i  in  3  load/store size and signedness
- mem_addr_i  in  XLEN  byte address
- wr_data_i  in  XLEN  store data, right-aligned
- alu_result_i  in  XLEN  ALU result
- rd_addr_i  in  5  destination register
- reg_write_i  in  1  op writes rd
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- rd_data_o  out  XLEN  write-back data
- rd_addr_o  out  5  destination register
- reg_write_o  out  1  write-back enable
- misaligned_o  out  1  access was misaligned; qualified by valid_o

Behaviour:
- Accept: an op is accepted when valid_i && ready_o. All inputs are captured into stage registers on acceptance.
- FSM states: IDLE, LOAD_WAIT, OUT.
  - IDLE, accept load -> LOAD_WAIT; load cycle counter with RD_LATENCY-1.
  - IDLE, accept store or non-memory op -> OUT.
  - LOAD_WAIT: count down to 0 -> OUT; formatted load data is registered.
  - OUT with ready_i: accept new op this cycle -> LOAD_WAIT/OUT as above; no new op -> IDLE.
  - OUT without ready_i: hold all outputs stable.
- ready_o = (state==IDLE) || (state==OUT && ready_i). ready_o is 0 in LOAD_WAIT.
- Latency from acceptance to valid_o:
  - non-memory op and store: 1 cycle.
  - load: RD_LATENCY+1 cycles.
- Back-to-back single-cycle ops give 1 op/cycle throughput.
- Stores: the RAM write occurs in the acceptance cycle.
  - Byte enables and lane shift come from funct3 and addr[2:0]: 000 SB, 001 SH, 010 SW, 011 SD.
  - Store result: valid_o with reg_write_o=0.
- Load formatting by funct3:
  - 000 LB, 001 LH, 010 LW, 011 LD: sign-extend.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend.
  - 111 is illegal: treated as LD.
- Lane extraction uses addr[2:0].
- Word index = mem_addr[$clog2(DEPTH_WORDS)+2:3]; higher address bits are ignored (wrap modulo RAM size).
- Misaligned accesses (H with addr[0]!=0, W with addr[1:0]!=0, D with addr[2:0]!=0):
  - no RAM access; result ready after 1 cycle.
  - misaligned_o=1, reg_write_o=0, rd_data_o=0.
- mem_read_i && mem_write_i both set: treated as a store.
- Write-back mux: mem_to_reg_i=1 -> rd_data_o=alu_result; 0 -> formatted load data (0 for non-loads).
- Reset (synchronous):
  - state=IDLE, counter=0.
  - valid_o=0, rd_data_o=0, rd_addr_o=0, reg_write_o=0, misaligned_o=0.
  - ready_o=1 in the cycle after reset.
- Reset mid-load: the pending read is discarded. RAM contents are not reset; an in-flight store is only guaranteed if its accept cycle completes before reset asserts.

Decomposition:
- Package mem_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU).
  - state_t enum {IDLE, LOAD_WAIT, OUT}.
  - Functions store_be(funct3, off), load_format(funct3, off, word), is_misaligned(funct3, off).
- Sub-module mem_stage_ram:
  - single-port, XLEN-wide, 8-bit byte-write-enable.
  - RD_LATENCY-stage registered read; no reset on the array.

Test Plan:
- SD 0x1122334455667788 @0x10, then LD @0x10, RD_LATENCY=1 -> load valid_o 2 cycles after accept, rd_data_o=0x1122334455667788, reg_write_o=1.
- SB 0x80 @0x13 over that word, then LB @0x13 and LBU @0x13 -> 0xFFFFFFFFFFFFFF80 and 0x0000000000000080; LD @0x10 -> 0x1122334480667788.
- LW @0x12 -> misaligned_o=1, reg_write_o=0, rd_data_o=0, valid_o after 1 cycle; RAM unchanged (re-read LD matches).
- Stream of 4 ALU ops with ready_i=1 -> valid_o every cycle, ready_o stays 1; ready_i=0 for 3 cycles -> outputs frozen, ready_o=0.
- RD_LATENCY=3, load accepted then rst_i asserted at cycle 2 -> next cycle valid_o=0, state IDLE, ready_o=1.
- Address wrap, DEPTH_WORDS=1024: SD 0xAA @0x0 then LD @0x2000 -> 0xAA.
